lerp_nch: RTL and testbench

LERP_NCH -- requirements
Module: lerp_nch

---
 rtl/lerp_nch.sv | 162 ++++++++++++++++
 tb/tb_lerp_nch.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/lerp_nch.sv
// Multi-channel bilinear interpolator sharing one iterative signed divider across all terms.
// Optional result saturation is enabled by defining LERP_NCH_SAT_EN (default: two's-complement wrap).
module lerp_nch #(
  parameter int WIDTH    = 32,
  parameter int CW       = 8,
  parameter int CHANNELS = 3
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [CHANNELS*WIDTH-1:0] p0,
  input  logic [CHANNELS*WIDTH-1:0] p1,
  input  logic [CHANNELS*WIDTH-1:0] p2,
  input  logic [CHANNELS*WIDTH-1:0] p3,
  input  logic [CW-1:0]             x,
  input  logic [CW-1:0]             y,
  input  logic [CW-1:0]             X,
  input  logic [CW-1:0]             Y,
  input  logic                      start,
  output logic                      ready,
  output logic                      done,
  output logic [CHANNELS*WIDTH-1:0] val,
  output logic                      dbz
);
  localparam int DW   = WIDTH + 2;
  localparam int NW   = DW + 2*CW;
  localparam int D    = NW;
  localparam int CNTW = $clog2(D + 1);
  localparam int CHW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DIV, S_ACC, S_DONE} state_t;

  state_t                           state_q, state_d;
  logic [CHANNELS-1:0][WIDTH-1:0]   p0_q, p1_q, p2_q, p3_q, p0_d, p1_d, p2_d, p3_d;
  logic [CHANNELS-1:0][WIDTH-1:0]   p0_a;
  logic [CW-1:0]                    x_q, y_q, ext_x_q, ext_y_q, x_d, y_d, ext_x_d, ext_y_d;
  logic [CHW-1:0]                   ch_q, ch_d;
  logic [1:0]                       kind_q, kind_d;
  logic [CNTW-1:0]                  cnt_q, cnt_d;
  logic [NW-1:0]                    quo_q, quo_d;
  logic [2*CW-1:0]                  rem_q, rem_d, den_q, den_d;
  logic                             neg_q, neg_d, dz_q, dz_d;
  logic [CHANNELS-1:0][DW-1:0]      acc_q, acc_d;
  logic [CHANNELS-1:0][WIDTH-1:0]   val_q, val_d;
  logic                             done_q, done_d, dbz_q, dbz_d;

  logic signed [DW-1:0] s0, s1, s2, s3, diff;
  logic signed [NW-1:0] diff_e, mul_op, num;
  logic [2*CW-1:0]      mul_u, den_sel, rem_diff;
  logic [NW-1:0]        num_mag;
  logic [2*CW:0]        rem_sh;
  logic                 ge;
  logic [DW-1:0]        q_lo, term;

  assign p0_a  = p0;
  assign ready = (state_q == S_IDLE);
  assign done  = done_q;
  assign val   = val_q;
  assign dbz   = dbz_q;

  function automatic logic [WIDTH-1:0] finish_ch(input logic [DW-1:0] a);
`ifdef LERP_NCH_SAT_EN
    logic [2:0] top;
    top = a[DW-1:WIDTH-1];
    if ((&top) || !(|top)) return a[WIDTH-1:0];
    return a[DW-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`else
    return a[WIDTH-1:0];
`endif
  endfunction

  always_comb begin
    // Numerator/denominator of the current term; all products fit NW bits exactly.
    s0 = $signed(p0_q[ch_q]);
    s1 = $signed(p1_q[ch_q]);
    s2 = $signed(p2_q[ch_q]);
    s3 = $signed(p3_q[ch_q]);
    case (kind_q)
      2'd0:    begin diff = s1 - s0;           mul_u = {{CW{1'b0}}, x_q}; den_sel = {{CW{1'b0}}, ext_x_q}; end
      2'd1:    begin diff = s2 - s0;           mul_u = {{CW{1'b0}}, y_q}; den_sel = {{CW{1'b0}}, ext_y_q}; end
      default: begin
        diff    = s0 - s1 + s3 - s2;
        mul_u   = {{CW{1'b0}}, x_q} * {{CW{1'b0}}, y_q};
        den_sel = {{CW{1'b0}}, ext_x_q} * {{CW{1'b0}}, ext_y_q};
      end
    endcase
    diff_e  = diff;
    mul_op  = $signed({{(NW-2*CW){1'b0}}, mul_u});
    num     = diff_e * mul_op;
    num_mag = num[NW-1] ? $unsigned(~num + 1'b1) : $unsigned(num);

    // Restoring division on magnitudes; sign is reapplied at accumulation.
    rem_sh   = {rem_q, quo_q[NW-1]};
    ge       = (rem_sh >= {1'b0, den_q});
    rem_diff = rem_sh[2*CW-1:0] - den_q;
    q_lo     = neg_q ? (~quo_q[DW-1:0] + 1'b1) : quo_q[DW-1:0];
    term     = dz_q ? '0 : q_lo;

    state_d = state_q;
    p0_d = p0_q; p1_d = p1_q; p2_d = p2_q; p3_d = p3_q;
    x_d = x_q; y_d = y_q; ext_x_d = ext_x_q; ext_y_d = ext_y_q;
    ch_d = ch_q; kind_d = kind_q; cnt_d = cnt_q;
    quo_d = quo_q; rem_d = rem_q; den_d = den_q; neg_d = neg_q; dz_d = dz_q;
    acc_d = acc_q; val_d = val_q; done_d = 1'b0; dbz_d = dbz_q;

    case (state_q)
      S_IDLE: if (start) begin
        p0_d = p0; p1_d = p1; p2_d = p2; p3_d = p3;
        x_d = x; y_d = y; ext_x_d = X; ext_y_d = Y;
        for (int c = 0; c < CHANNELS; c++) acc_d[c] = {{2{p0_a[c][WIDTH-1]}}, p0_a[c]};
        ch_d = '0; kind_d = 2'd0; dbz_d = 1'b0;
        state_d = S_LOAD;
      end
      S_LOAD: begin
        quo_d = num_mag; neg_d = num[NW-1]; den_d = den_sel;
        rem_d = '0; dz_d = (den_sel == '0); cnt_d = '0;
        state_d = S_DIV;
      end
      S_DIV: begin
        quo_d = {quo_q[NW-2:0], ge};
        rem_d = ge ? rem_diff : rem_sh[2*CW-1:0];
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNTW'(D-1)) state_d = S_ACC;
      end
      S_ACC: begin
        acc_d[ch_q] = acc_q[ch_q] + term;
        if (dz_q) dbz_d = 1'b1;
        state_d = S_LOAD;
        if (kind_q == 2'd2) begin
          kind_d = 2'd0;
          if (ch_q == CHW'(CHANNELS-1)) state_d = S_DONE;
          else ch_d = ch_q + 1'b1;
        end else begin
          kind_d = kind_q + 2'd1;
        end
      end
      S_DONE: begin
        for (int c = 0; c < CHANNELS; c++) val_d[c] = finish_ch(acc_q[c]);
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_IDLE;
      p0_q <= '0; p1_q <= '0; p2_q <= '0; p3_q <= '0;
      x_q <= '0; y_q <= '0; ext_x_q <= '0; ext_y_q <= '0;
      ch_q <= '0; kind_q <= '0; cnt_q <= '0;
      quo_q <= '0; rem_q <= '0; den_q <= '0; neg_q <= 1'b0; dz_q <= 1'b0;
      acc_q <= '0; val_q <= '0; done_q <= 1'b0; dbz_q <= 1'b0;
    end else begin
      state_q <= state_d;
      p0_q <= p0_d; p1_q <= p1_d; p2_q <= p2_d; p3_q <= p3_d;
      x_q <= x_d; y_q <= y_d; ext_x_q <= ext_x_d; ext_y_q <= ext_y_d;
      ch_q <= ch_d; kind_q <= kind_d; cnt_q <= cnt_d;
      quo_q <= quo_d; rem_q <= rem_d; den_q <= den_d; neg_q <= neg_d; dz_q <= dz_d;
      acc_q <= acc_d; val_q <= val_d; done_q <= done_d; dbz_q <= dbz_d;
    end
  end
endmodule

// File: tb/tb_lerp_nch.sv
// Directed plus randomized checks of lerp_nch against a plain-arithmetic interpolation model.
module tb_lerp_nch;
  localparam int W = 16, CW = 4, CH = 2, LAT = 169;

  logic clock = 1'b0, reset = 1'b1, start = 1'b0;
  logic [CH*W-1:0] p0 = '0, p1 = '0, p2 = '0, p3 = '0, val;
  logic [CW-1:0] x = '0, y = '0, X = '0, Y = '0;
  logic ready, done, dbz;

  int checks = 0, failures = 0;
  longint pv[CH][4];
  longint xs, ys, bx, by;
  longint exp_v[CH];

  always #5 clock = ~clock;

  lerp_nch #(.WIDTH(W), .CW(CW), .CHANNELS(CH)) dut (
    .clock(clock), .reset(reset), .p0(p0), .p1(p1), .p2(p2), .p3(p3),
    .x(x), .y(y), .X(X), .Y(Y), .start(start),
    .ready(ready), .done(done), .val(val), .dbz(dbz));

  task automatic check(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic longint wrapn(input longint v, input int n);
    return (v <<< (64 - n)) >>> (64 - n);
  endfunction

  // Reference: real-valued formula terms with truncating division, 18-bit quotient/accumulator.
  function automatic longint model_ch(input int c);
    longint num[3], den[3], acc, q;
    num[0] = (pv[c][1] - pv[c][0]) * xs;                               den[0] = bx;
    num[1] = (pv[c][2] - pv[c][0]) * ys;                               den[1] = by;
    num[2] = (pv[c][0] - pv[c][1] + pv[c][3] - pv[c][2]) * xs * ys;    den[2] = bx * by;
    acc = pv[c][0];
    for (int i = 0; i < 3; i++) begin
      q = (den[i] == 0) ? 0 : num[i] / den[i];
      acc = wrapn(acc + wrapn(q, W + 2), W + 2);
    end
`ifdef LERP_NCH_SAT_EN
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    return acc;
`else
    return wrapn(acc, W);
`endif
  endfunction

  task automatic drive();
    for (int c = 0; c < CH; c++) begin
      p0[c*W +: W] = W'(pv[c][0]); p1[c*W +: W] = W'(pv[c][1]);
      p2[c*W +: W] = W'(pv[c][2]); p3[c*W +: W] = W'(pv[c][3]);
    end
    x = CW'(xs); y = CW'(ys); X = CW'(bx); Y = CW'(by);
  endtask

  task automatic scramble();
    p0 = {$urandom, $urandom}; p1 = {$urandom, $urandom};
    p2 = {$urandom, $urandom}; p3 = {$urandom, $urandom};
    x = CW'($urandom); y = CW'($urandom); X = CW'($urandom); Y = CW'($urandom);
  endtask

  task automatic rand_inputs();
    logic [W-1:0] r;
    for (int c = 0; c < CH; c++)
      for (int k = 0; k < 4; k++) begin
        r = W'($urandom);
        pv[c][k] = longint'($signed(r));
      end
    xs = $urandom_range(0, 15); ys = $urandom_range(0, 15);
    bx = $urandom_range(0, 15); by = $urandom_range(0, 15);
  endtask

  task automatic run_op(input string tag, input bit busy_start);
    int n;
    drive();
    check({tag, ".ready_pre"}, ready, 1);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    scramble();
    check({tag, ".dbz_clr"}, dbz, 0);
    n = 0;
    while (!done && n < 400) begin
      start = (busy_start && n == 20);
      @(posedge clock); #1;
      n++;
    end
    start = 1'b0;
    check({tag, ".latency"}, n, LAT);
    for (int c = 0; c < CH; c++) begin
      exp_v[c] = model_ch(c);
      check($sformatf("%s.val%0d", tag, c), $signed(val[c*W +: W]), exp_v[c]);
    end
    check({tag, ".dbz"}, dbz, (bx == 0 || by == 0) ? 1 : 0);
    check({tag, ".ready_post"}, ready, 1);
  endtask

  task automatic idle_watch(input string tag, input int cycles);
    int seen;
    seen = 0;
    repeat (cycles) begin
      @(posedge clock); #1;
      if (done) seen++;
    end
    check({tag, ".no_done"}, seen, 0);
    check({tag, ".ready"}, ready, 1);
  endtask

  task automatic set_ch(input int c, input longint a, input longint b, input longint d, input longint e);
    pv[c][0] = a; pv[c][1] = b; pv[c][2] = d; pv[c][3] = e;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clock);
    #1;
    check("rst.ready", ready, 1);
    check("rst.done", done, 0);
    check("rst.dbz", dbz, 0);
    check("rst.val", val, 0);
    reset = 1'b0;

    // Basic interpolation with a start pulse while busy
    set_ch(0, 0, 100, 200, 300); set_ch(1, 10, 10, 10, 50);
    xs = 1; bx = 2; ys = 1; by = 2;
    run_op("basic", 1'b1);
    check("basic.ch0_const", $signed(val[0 +: W]), 150);
    idle_watch("busy_start", 200);
    scramble();
    repeat (5) @(posedge clock);
    #1;
    check("hold.ch0", $signed(val[0 +: W]), exp_v[0]);
    check("hold.ch1", $signed(val[W +: W]), exp_v[1]);

    // Cross term
    xs = 3; bx = 4; ys = 2; by = 4;
    run_op("cross", 1'b0);
    check("cross.ch1_const", $signed(val[W +: W]), 25);

    // Truncation toward zero
    set_ch(0, 0, -7, 0, -7); set_ch(1, 1, 2, 3, 4);
    xs = 1; bx = 2; ys = 0; by = 2;
    run_op("trunc", 1'b0);
    check("trunc.ch0_const", $signed(val[0 +: W]), -3);

    // Zero denominator, dbz held in idle, cleared by next accept
    set_ch(0, 5, 9, 5, 9);
    xs = 1; bx = 0; ys = 0; by = 1;
    run_op("dbz", 1'b0);
    check("dbz.ch0_const", $signed(val[0 +: W]), 5);
    repeat (10) @(posedge clock);
    #1;
    check("dbz.held", dbz, 1);
    bx = 1;
    run_op("dbz_clear", 1'b0);

    // Overflow: saturate or wrap
    set_ch(0, 0, 30000, 0, 30000);
    xs = 2; bx = 1; ys = 0; by = 1;
    run_op("ovf", 1'b0);
`ifdef LERP_NCH_SAT_EN
    check("ovf.ch0_const", $signed(val[0 +: W]), 32767);
`else
    check("ovf.ch0_const", $signed(val[0 +: W]), -5536);
`endif

    // Reset 50 cycles into an operation, with a busy start beforehand
    rand_inputs(); drive();
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    repeat (49) @(posedge clock);
    #1;
    check("midrst.busy_ready", ready, 0);
    start = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("midrst.ready", ready, 1);
    check("midrst.done", done, 0);
    check("midrst.val", val, 0);
    check("midrst.dbz", dbz, 0);
    idle_watch("midrst", 250);

    // Reset wins over start in the same cycle
    start = 1'b1; reset = 1'b1;
    @(posedge clock); #1;
    start = 1'b0; reset = 1'b0;
    check("rst_prio.ready", ready, 1);
    idle_watch("rst_prio", 200);

    // Randomized operations
    for (int i = 0; i < 12; i++) begin
      rand_inputs();
      run_op($sformatf("rand%0d", i), i[0]);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
